// File: rtl/frame_rate_pkg.sv
// Shared mode codes, vtotal defaults and schedule geometry for the
// variable-frame-rate scheduler.
package frame_rate_pkg;

  localparam int unsigned SLOT_COUNT = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned VTOTAL_W   = 13;

  typedef enum logic [NIBBLE_W-1:0] {
    FR_30  = 4'd0,
    FR_60  = 4'd1,
    FR_90  = 4'd2,
    FR_120 = 4'd3,
    FR_144 = 4'd4
  } fr_mode_e;

  localparam logic [NIBBLE_W-1:0] FR_MODE_MAX = 4'd4;

  localparam logic [VTOTAL_W-1:0] VTOTAL30_DEF  = 13'd5280;
  localparam logic [VTOTAL_W-1:0] VTOTAL60_DEF  = 13'd2640;
  localparam logic [VTOTAL_W-1:0] VTOTAL90_DEF  = 13'd1760;
  localparam logic [VTOTAL_W-1:0] VTOTAL120_DEF = 13'd1320;
  localparam logic [VTOTAL_W-1:0] VTOTAL144_DEF = 13'd1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } sched_state_e;

endpackage

// File: rtl/fr_vtotal_lut.sv
// Mode code to vtotal lookup; unknown codes fall back to the 144 Hz timing
// and raise the invalid flag.
module fr_vtotal_lut
  import frame_rate_pkg::*;
#(
  parameter logic [VTOTAL_W-1:0] VTOTAL30  = VTOTAL30_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL60  = VTOTAL60_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL90  = VTOTAL90_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL120 = VTOTAL120_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL144 = VTOTAL144_DEF
) (
  input  logic [NIBBLE_W-1:0] mode,
  output logic [VTOTAL_W-1:0] vtotal,
  output logic                invalid
);

  always_comb begin
    invalid = 1'b0;
    vtotal  = VTOTAL144;
    case (mode)
      FR_30:   vtotal = VTOTAL30;
      FR_60:   vtotal = VTOTAL60;
      FR_90:   vtotal = VTOTAL90;
      FR_120:  vtotal = VTOTAL120;
      FR_144:  vtotal = VTOTAL144;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/frame_rate_sched.sv
// Per-frame refresh-rate scheduler: steps an 8-slot mode schedule at each
// frame_end; new schedules wait in a shadow register until a frame boundary.
module frame_rate_sched
  import frame_rate_pkg::*;
#(
  parameter logic [VTOTAL_W-1:0] VTOTAL30   = VTOTAL30_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL60   = VTOTAL60_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL90   = VTOTAL90_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL120  = VTOTAL120_DEF,
  parameter logic [VTOTAL_W-1:0] VTOTAL144  = VTOTAL144_DEF,
  parameter logic [NIBBLE_W-1:0] RESET_MODE = 4'd4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frame_end,
  input  logic                                sched_valid,
  output logic                                sched_ready,
  input  logic [SLOT_COUNT*NIBBLE_W-1:0]      sched_modes,
  input  logic [SLOT_W-1:0]                   sched_len,
  output logic [NIBBLE_W-1:0]                 fr_mode,
  output logic [VTOTAL_W-1:0]                 vtotal,
  output logic [SLOT_W-1:0]                   slot,
  output logic                                pending,
  output logic                                mode_err,
  output logic [15:0]                         frame_cnt
);

  sched_state_e                    state_reg, state_next;
  logic [SLOT_COUNT*NIBBLE_W-1:0]  shadow_modes_reg, active_modes_reg;
  logic [SLOT_W-1:0]               shadow_len_reg, active_len_reg;
  logic [SLOT_W-1:0]               slot_reg, slot_next;
  logic [NIBBLE_W-1:0]             fr_mode_reg;
  logic [VTOTAL_W-1:0]             vtotal_reg;
  logic                            mode_err_reg;
  logic [15:0]                     frame_cnt_reg;

  logic                            accept;
  logic                            take_shadow;
  logic [SLOT_W-1:0]               last_slot;
  logic [SLOT_COUNT*NIBBLE_W-1:0]  modes_sel;
  logic [NIBBLE_W-1:0]             nib_arr [SLOT_COUNT];
  logic [NIBBLE_W-1:0]             next_nibble;
  logic [VTOTAL_W-1:0]             lut_vtotal;
  logic                            lut_invalid;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (sched_valid) state_next = ST_PEND;
      ST_PEND: if (frame_end)   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sched_ready = (state_reg == ST_IDLE);
    pending     = (state_reg == ST_PEND);
  end

  assign accept      = sched_valid && (state_reg == ST_IDLE);
  assign take_shadow = frame_end && (state_reg == ST_PEND);
  // A length of 0 encodes 8 slots; the 3-bit wrap of len-1 yields 7 for free.
  assign last_slot   = active_len_reg - 3'd1;
  assign slot_next   = take_shadow ? '0
                     : (slot_reg == last_slot) ? '0 : slot_reg + 3'd1;
  assign modes_sel   = take_shadow ? shadow_modes_reg : active_modes_reg;

  generate
    for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_nib
      assign nib_arr[gi] = modes_sel[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  assign next_nibble = nib_arr[slot_next];

  fr_vtotal_lut #(
    .VTOTAL30  (VTOTAL30),
    .VTOTAL60  (VTOTAL60),
    .VTOTAL90  (VTOTAL90),
    .VTOTAL120 (VTOTAL120),
    .VTOTAL144 (VTOTAL144)
  ) u_lut (
    .mode    (next_nibble),
    .vtotal  (lut_vtotal),
    .invalid (lut_invalid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_modes_reg <= '0;
      shadow_len_reg   <= '0;
      active_modes_reg <= {SLOT_COUNT{RESET_MODE}};
      active_len_reg   <= 3'd1;
      slot_reg         <= '0;
      fr_mode_reg      <= RESET_MODE;
      vtotal_reg       <= VTOTAL144;
      mode_err_reg     <= 1'b0;
      frame_cnt_reg    <= '0;
    end else begin
      if (accept) begin
        shadow_modes_reg <= sched_modes;
        shadow_len_reg   <= sched_len;
      end
      if (take_shadow) begin
        active_modes_reg <= shadow_modes_reg;
        active_len_reg   <= shadow_len_reg;
      end
      if (frame_end) begin
        slot_reg      <= slot_next;
        fr_mode_reg   <= lut_invalid ? FR_MODE_MAX : next_nibble;
        vtotal_reg    <= lut_vtotal;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      mode_err_reg <= frame_end && lut_invalid;
    end
  end

  assign fr_mode   = fr_mode_reg;
  assign vtotal    = vtotal_reg;
  assign slot      = slot_reg;
  assign mode_err  = mode_err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_frame_rate_sched.sv
// Self-checking bench for frame_rate_sched: table-driven schedules plus
// hand-written sequences for same-cycle handshake and reset-while-pending.
module tb_frame_rate_sched;

  logic        clk;
  logic        reset;
  logic        frame_end;
  logic        sched_valid;
  logic        sched_ready;
  logic [31:0] sched_modes;
  logic [2:0]  sched_len;
  logic [3:0]  fr_mode;
  logic [12:0] vtotal;
  logic [2:0]  slot;
  logic        pending;
  logic        mode_err;
  logic [15:0] frame_cnt;

  frame_rate_sched dut (
    .clk         (clk),
    .reset       (reset),
    .frame_end   (frame_end),
    .sched_valid (sched_valid),
    .sched_ready (sched_ready),
    .sched_modes (sched_modes),
    .sched_len   (sched_len),
    .fr_mode     (fr_mode),
    .vtotal      (vtotal),
    .slot        (slot),
    .pending     (pending),
    .mode_err    (mode_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  mode;
    logic [12:0] vtotal;
    logic [2:0]  slot;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] modes;
    logic [2:0]  len;
    int          nframes;
    logic [35:0] exp_nibs;  // raw slot nibble expected on frame i at [4i+:4]
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[3];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_model = 0;

  function automatic logic [12:0] vt_ref(input logic [3:0] m);
    case (m)
      4'd0:    return 13'd5280;
      4'd1:    return 13'd2640;
      4'd2:    return 13'd1760;
      4'd3:    return 13'd1320;
      default: return 13'd1100;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] nib, input logic [2:0] s, input logic [15:0] c);
    exp_t e;
    e.err    = (nib > 4'd4);
    e.mode   = e.err ? 4'd4 : nib;
    e.vtotal = vt_ref(e.mode);
    e.slot   = s;
    e.cnt    = c;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse frame_end for one cycle and compare against the scoreboard entry.
  task automatic frame_and_check(input logic [3:0] nib, input logic [2:0] s);
    exp_t e;
    cnt_model++;
    sb_q.push_back(mk_exp(nib, s, cnt_model[15:0]));
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    e = sb_q.pop_front();
    $display("frame: mode=%0d vtotal=%0d slot=%0d err=%0d cnt=%0d", fr_mode, vtotal, slot, mode_err, frame_cnt);
    chk("fr_mode", fr_mode, e.mode);
    chk("vtotal", vtotal, e.vtotal);
    chk("slot", slot, e.slot);
    chk("mode_err", mode_err, e.err);
    chk("frame_cnt", frame_cnt, e.cnt);
  endtask

  task automatic load_sched(input logic [31:0] m, input logic [2:0] l);
    sched_modes = m;
    sched_len   = l;
    sched_valid = 1'b1;
    chk("ready_before_load", sched_ready, 1);
    @(posedge clk); #1;
    sched_valid = 1'b0;
    $display("load: modes=%h len=%0d pending=%0d ready=%0d", m, l, pending, sched_ready);
    chk("pending_after_load", pending, 1);
    chk("ready_after_load", sched_ready, 0);
  endtask

  initial begin
    vecs[0] = '{modes: 32'h0000_3210, len: 3'd4, nframes: 5, exp_nibs: 36'h0_0000_3210};
    vecs[1] = '{modes: 32'h4321_0432, len: 3'd0, nframes: 9, exp_nibs: 36'h2_4321_0432};
    vecs[2] = '{modes: 32'h0000_00A1, len: 3'd2, nframes: 3, exp_nibs: 36'h0_0000_01A1};

    reset = 1'b1; frame_end = 1'b0; sched_valid = 1'b0;
    sched_modes = '0; sched_len = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_fr_mode", fr_mode, 4);
    chk("rst_vtotal", vtotal, 1100);
    chk("rst_slot", slot, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", sched_ready, 1);
    chk("rst_mode_err", mode_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    for (int i = 0; i < 3; i++) frame_and_check(4'd4, 3'd0);

    for (int v = 0; v < 3; v++) begin
      int eff_len;
      logic [3:0] last_mode;
      eff_len = (vecs[v].len == 3'd0) ? 8 : int'(vecs[v].len);
      load_sched(vecs[v].modes, vecs[v].len);
      for (int i = 0; i < vecs[v].nframes; i++)
        frame_and_check(vecs[v].exp_nibs[4*i +: 4], 3'(i % eff_len));
      chk("pending_cleared", pending, 0);
      last_mode = fr_mode;
      @(posedge clk); #1;
      chk("stable_mode_err", mode_err, 0);
      chk("stable_fr_mode", fr_mode, 32'(mk_exp(vecs[v].exp_nibs[4*(vecs[v].nframes-1) +: 4], 3'd0, 16'd0).mode));
      chk("stable_vs_prev", fr_mode, last_mode);
    end

    // Same-cycle valid and frame_end: active {1,A} len 2 sits at slot 0.
    sched_modes = 32'h0000_0002; sched_len = 3'd1; sched_valid = 1'b1;
    frame_and_check(4'hA, 3'd1);
    chk("samecyc_pending", pending, 1);
    chk("samecyc_ready", sched_ready, 0);
    sched_modes = 32'h3333_3333;
    repeat (2) begin
      @(posedge clk); #1;
      chk("pend_ready_low", sched_ready, 0);
      chk("pend_mode_hold", fr_mode, 4);
    end
    sched_valid = 1'b0;
    frame_and_check(4'd2, 3'd0);
    frame_and_check(4'd2, 3'd0);

    // Back-to-back frame_end pulses on a two-slot schedule.
    load_sched(32'h0000_0013, 3'd2);
    frame_and_check(4'd3, 3'd0);
    frame_and_check(4'd1, 3'd1);
    frame_and_check(4'd3, 3'd0);

    // Reset while a schedule is pending discards it.
    load_sched(32'h0000_0000, 3'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstp_pending", pending, 0);
    chk("rstp_fr_mode", fr_mode, 4);
    chk("rstp_vtotal", vtotal, 1100);
    chk("rstp_frame_cnt", frame_cnt, 0);
    chk("rstp_ready", sched_ready, 1);
    cnt_model = 0;
    frame_and_check(4'd4, 3'd0);
    frame_and_check(4'd4, 3'd0);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
